seq_add_controller: RTL and testbench
=====================================

Name: seq_add_controller

Overview:
Multi-cycle 32-bit adder/subtractor. It reuses one narrow SLICE-bit ripple-adder slice over successive cycles, sequenced by an internal FSM, with a start/busy/done handshake. It trades latency for area and serves as the shared arithmetic resource for the lab datapath. Operands and carry are latched on start, so callers may change the inputs while the block is busy.

Parameters:
WIDTH, 32, operand and result width; must be an integer multiple of SLICE.
SLICE, 8, bits added per cycle. N = WIDTH/SLICE slice steps (default 4).

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
start  input  1  request pulse; sampled only in IDLE or DONE
op_sub  input  1  0 = A+B+carry_in; 1 = A-B (A + ~B + 1; carry_in ignored)
input_a  input  WIDTH  operand A
input_b  input  WIDTH  operand B
carry_in  input  1  carry into bit 0 (add only)
busy  output  1  high while slices are being processed
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result register
carry_out  output  1  carry out of MSB (for sub: 1 = no borrow)
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, any state, including mid-operation): state IDLE; busy=0, done=0, sum=0, carry_out=0, overflow=0. Internal operand regs, slice index and carry are cleared. An aborted operation produces no done.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN.
  - RUN: process slice idx. idx==N-1 -> DONE.
  - DONE: start=1 -> RUN (back-to-back accepted); else -> IDLE.
- Start accept at edge E0:
  - latch A into a_r.
  - latch B into b_r, with b_r = op_sub ? ~B : B.
  - carry register c = op_sub ? 1 : carry_in.
  - idx = 0; sum cleared to 0; busy=1 from E0.
- RUN, edge Ek (k=1..N):
  - {c_next, s} = a_r[slice idx] + b_r[slice idx] + c.
  - s written to sum[idx*SLICE +: SLICE]; c updated; idx incremented.
  - On the final slice only: carry_out = c_next; overflow = carry into bit WIDTH-1 XOR c_next.
- Latency: edge EN moves the FSM to DONE. busy=0 and done=1 for exactly one cycle, N cycles after the start edge.
- Results: sum, carry_out and overflow hold after DONE until the next accepted start.
- start while in RUN: ignored, not queued.
- start in DONE: accepted, so done=1 and busy=1 appear in the same cycle only in that case. The new operation clears sum on that edge.
- sum is only meaningful while busy=0.
- All additions are unsigned WIDTH-bit with wrap-around. Overflow is interpreted as two's complement.

Optional Feature:
SEQ_ADD_ZERO_SKIP_EN
- Defined: after processing slice idx (< N-1), if c_next==0 and a_r and b_r are all-zero above that slice, go directly to DONE.
  - The remaining sum bits stay 0; carry_out=0.
  - overflow = 0 unless the skipped-to MSB logic applies, which it cannot, since the upper bits are zero. overflow=0.
  - Latency becomes 1..N cycles.
  - Subtraction never skips, because ~B has upper ones unless B is all-ones.
- Undefined: fixed latency of N cycles and no skip comparators.

Test Plan:
1. Add 321937 + 1172056, carry_in=1 -> done 4 cycles after start; sum=1493994, carry_out=0, overflow=0.
2. Add 415362004 + 23907432, carry_in=1 -> sum=439269437, carry_out=0; busy high for 4 cycles. Changing input_a during busy leaves the result unchanged.
3. Sub 23 - 12 -> sum=11, carry_out=1. Sub 12 - 23 -> sum=0xFFFFFFF5, carry_out=0, overflow=0.
4. Add 0xFFFFFFFF + 0, carry_in=1 -> sum=0, carry_out=1, overflow=0. Add 0x7FFFFFFF + 1 -> sum=0x80000000, overflow=1, carry_out=0.
5. Assert rst for 1 cycle at cycle 2 of an add -> all outputs 0, IDLE, no done. Start re-issued in the done cycle of a prior op -> second result correct 4 cycles later.
6. SEQ_ADD_ZERO_SKIP_EN defined: 23 + 12, carry_in=0 -> done 1 cycle after start, sum=35. Without the macro -> done after 4 cycles, same sum.

Source files
------------

// File: rtl/seq_add_controller.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one SLICE-bit ripple slice per cycle.
// Optional early completion on all-zero upper operand bits: define SEQ_ADD_ZERO_SKIP_EN.
module seq_add_controller #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  a_r, b_r, sum_r;
  logic [IDXW-1:0]   idx;
  logic              c;
  logic              carry_out_r, overflow_r;

  logic [SLICE-1:0]  a_sl, b_sl, s;
  logic              c_next;
  logic              last;
  logic              accept;
  logic              skip;

  assign a_sl   = a_r[idx*SLICE +: SLICE];
  assign b_sl   = b_r[idx*SLICE +: SLICE];
  assign last   = (idx == IDXW'(N - 1));
  assign accept = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    {c_next, s} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, c};
  end

`ifdef SEQ_ADD_ZERO_SKIP_EN
  logic [WIDTH-1:0] upper;

  // Bits above the current slice; with no carry pending they cannot change the result.
  always_comb begin
    upper = (a_r | b_r) >> ((int'(idx) + 1) * SLICE);
    skip  = !last && !c_next && (upper == '0);
  end
`else
  assign skip = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last || skip) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      idx         <= '0;
      c           <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (accept) begin
      a_r         <= input_a;
      b_r         <= op_sub ? ~input_b : input_b;
      c           <= op_sub ? 1'b1 : carry_in;
      idx         <= '0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (state == RUN) begin
      sum_r[idx*SLICE +: SLICE] <= s;
      c   <= c_next;
      idx <= idx + 1'b1;
      if (last) begin
        carry_out_r <= c_next;
        // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
        overflow_r  <= (a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ s[SLICE-1]) ^ c_next;
      end
    end
  end

  // A start accepted in DONE raises busy in the same cycle as the done pulse.
  assign busy      = (state == RUN) || ((state == DONE) && start);
  assign done      = (state == DONE);
  assign sum       = sum_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_seq_add_controller.sv
// Directed self-checking bench for seq_add_controller (default WIDTH=32, SLICE=8).
module tb_seq_add_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_sub;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        carry_out;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  seq_add_controller dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_sub    (op_sub),
    .input_a   (input_a),
    .input_b   (input_b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Issues one operation and waits (bounded) for done; returns latency and busy-cycle count.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic sub, input logic mutate, output int lat, output int bcnt);
    @(negedge clk);
    input_a = a; input_b = b; carry_in = ci; op_sub = sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      if (mutate) begin
        input_a = ~input_a; input_b = input_b + 32'h0101_0101;
        carry_in = ~carry_in; op_sub = ~op_sub;
      end
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic check_result(input string name, input logic [31:0] exp_sum,
                              input logic exp_co, input logic exp_ov);
    tests++;
    if ({sum, carry_out, overflow} !== {exp_sum, exp_co, exp_ov}) begin
      fails++;
      $display("FAIL %s: sum=%h co=%b ov=%b, expected sum=%h co=%b ov=%b",
               name, sum, carry_out, overflow, exp_sum, exp_co, exp_ov);
    end
  endtask

  task automatic check_lat(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: latency=%0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; input_a = '0; input_b = '0; carry_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    tests++;
    if ({busy, done, sum, carry_out, overflow} !== 35'd0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h co=%b ov=%b, expected all 0",
               busy, done, sum, carry_out, overflow);
    end
  endtask

  task automatic test_add();
    int lat, bcnt;
    run_op(32'd321937, 32'd1172056, 1'b1, 1'b0, 1'b0, lat, bcnt);
`ifdef SEQ_ADD_ZERO_SKIP_EN
    check_lat("add1_latency", lat, 3);
`else
    check_lat("add1_latency", lat, 4);
`endif
    check_result("add1_result", 32'd1493994, 1'b0, 1'b0);
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse_width: done=%b, expected 0", done);
    end
    @(posedge clk); #1;
    check_result("add1_hold", 32'd1493994, 1'b0, 1'b0);

    run_op(32'd415362004, 32'd23907432, 1'b1, 1'b0, 1'b1, lat, bcnt);
    check_lat("add2_latency", lat, 4);
    check_lat("add2_busy_cycles", bcnt, 4);
    check_result("add2_result_inputs_changed", 32'd439269437, 1'b0, 1'b0);
  endtask

  task automatic test_sub();
    int lat, bcnt;
    run_op(32'd23, 32'd12, 1'b1, 1'b1, 1'b0, lat, bcnt);
    check_lat("sub1_latency", lat, 4);
    check_result("sub_23_12", 32'd11, 1'b1, 1'b0);
    run_op(32'd12, 32'd23, 1'b0, 1'b1, 1'b0, lat, bcnt);
    check_result("sub_12_23", 32'hFFFF_FFF5, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b0, lat, bcnt);
    check_result("sub_min_minus_1", 32'h7FFF_FFFF, 1'b1, 1'b1);
  endtask

  task automatic test_boundaries();
    int lat, bcnt;
    run_op(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0, lat, bcnt);
    check_result("add_wrap", 32'd0, 1'b1, 1'b0);
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, lat, bcnt);
    check_result("add_signed_ovf", 32'h8000_0000, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    input_a = 32'h1234_5678; input_b = 32'h0101_0101; carry_in = 1'b0; op_sub = 1'b0;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, sum, carry_out, overflow} !== 35'd0) begin
      fails++;
      $display("FAIL abort_outputs: busy=%b done=%b sum=%h co=%b ov=%b, expected all 0",
               busy, done, sum, carry_out, overflow);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL abort_no_done: active cycles=%0d, expected 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    run_op(32'h0100_0000, 32'h0200_0000, 1'b0, 1'b0, 1'b0, lat, bcnt);
    check_result("b2b_first", 32'h0300_0000, 1'b0, 1'b0);
    // Still in the done cycle: re-issue start before the next edge.
    input_a = 32'h1234_5678; input_b = 32'h1111_1111; carry_in = 1'b0; op_sub = 1'b0;
    start = 1'b1;
    #1;
    tests++;
    if ({done, busy} !== 2'b11) begin
      fails++;
      $display("FAIL b2b_overlap: done=%b busy=%b, expected 1 1", done, busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if ({done, busy, sum} !== {2'b01, 32'd0}) begin
      fails++;
      $display("FAIL b2b_clear: done=%b busy=%b sum=%h, expected 0 1 00000000", done, busy, sum);
    end
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_lat("b2b_latency", lat, 4);
    check_result("b2b_second", 32'h2345_6789, 1'b0, 1'b0);
  endtask

  task automatic test_zero_skip();
    int lat, bcnt;
    run_op(32'd23, 32'd12, 1'b0, 1'b0, 1'b0, lat, bcnt);
`ifdef SEQ_ADD_ZERO_SKIP_EN
    check_lat("small_add_latency", lat, 1);
`else
    check_lat("small_add_latency", lat, 4);
`endif
    check_result("small_add_result", 32'd35, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_boundaries();
    test_abort();
    test_back_to_back();
    test_zero_skip();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
